// File: rtl/fft64_frame_ctrl_if.sv
// Streaming bundle around the fft64 frame controller: upstream samples, core
// feed and return paths, result stream, and status/error lines.
interface fft64_frame_ctrl_if #(
    parameter int DW = 24
);
    logic                 s_valid;
    logic                 s_ready;
    logic signed [DW-1:0] s_real;
    logic signed [DW-1:0] s_imag;
    logic                 s_last;

    logic                 fft_din_valid;
    logic signed [DW-1:0] fft_din_real;
    logic signed [DW-1:0] fft_din_imag;
    logic                 fft_dout_valid;
    logic signed [DW-1:0] fft_dout_real;
    logic signed [DW-1:0] fft_dout_imag;

    logic                 m_valid;
    logic signed [DW-1:0] m_real;
    logic signed [DW-1:0] m_imag;
    logic                 m_first;
    logic                 m_last;
    logic [7:0]           m_frame;

    logic                 busy;
    logic                 err_framing;
    logic                 err_clr;

    // Controller side
    modport slave (
        input  s_valid, s_real, s_imag, s_last,
        input  fft_dout_valid, fft_dout_real, fft_dout_imag,
        input  err_clr,
        output s_ready,
        output fft_din_valid, fft_din_real, fft_din_imag,
        output m_valid, m_real, m_imag, m_first, m_last, m_frame,
        output busy, err_framing
    );

    // Environment side: upstream source, FFT core and result sink
    modport master (
        output s_valid, s_real, s_imag, s_last,
        output fft_dout_valid, fft_dout_real, fft_dout_imag,
        output err_clr,
        input  s_ready,
        input  fft_din_valid, fft_din_real, fft_din_imag,
        input  m_valid, m_real, m_imag, m_first, m_last, m_frame,
        input  busy, err_framing
    );
endinterface

// File: rtl/fft64_frame_ctrl.sv
// Frame controller for a streaming FFT core: buffers one N-sample frame, bursts
// it into the core contiguously, then tags returning bins with first/last/frame.
module fft64_frame_ctrl #(
    parameter int DW = 24,
    parameter int N  = 64
) (
    input  logic                clk,
    input  logic                rstn,
    fft64_frame_ctrl_if.slave   ctrl_io
);
    localparam int            AW       = $clog2(N);
    localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

    typedef enum logic {
        FILL  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]        rd_addr;
    logic                 s_ready_q, s_ready_d;
    logic                 din_valid_q, din_valid_d;
    logic signed [DW-1:0] rd_real_q, rd_imag_q;

    logic [1:0]           inflight_q, inflight_d;
    logic [AW-1:0]        bin_q, bin_d;
    logic [7:0]           frame_q, frame_d;
    logic                 m_valid_q, m_valid_d;
    logic signed [DW-1:0] m_real_q, m_real_d;
    logic signed [DW-1:0] m_imag_q, m_imag_d;
    logic                 m_first_q, m_first_d;
    logic                 m_last_q, m_last_d;
    logic                 err_q, err_d;

    logic                 accept;
    logic                 burst_done;
    logic                 fill_err;
    logic                 fwd;
    logic                 orphan;
    logic                 frame_done;
    logic                 overflow;
    logic                 err_set;

    logic signed [DW-1:0] buf_real [N];
    logic signed [DW-1:0] buf_imag [N];

    assign accept = ctrl_io.s_valid && s_ready_q && (state_q == FILL);

    // Frame buffer with registered read. While filling, the read port sits on
    // entry 0 so the first burst word is already registered when BURST begins.
    assign rd_addr = (state_q == BURST) ? rd_ptr_q : '0;

    always_ff @(posedge clk) begin
        if (accept) begin
            buf_real[wr_ptr_q] <= ctrl_io.s_real;
            buf_imag[wr_ptr_q] <= ctrl_io.s_imag;
        end
        rd_real_q <= buf_real[rd_addr];
        rd_imag_q <= buf_imag[rd_addr];
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        din_valid_d = 1'b0;
        burst_done  = 1'b0;
        fill_err    = 1'b0;
        case (state_q)
            FILL: begin
                if (accept) begin
                    if (wr_ptr_q == LAST_IDX) begin
                        state_d     = BURST;
                        wr_ptr_d    = '0;
                        rd_ptr_d    = AW'(1);
                        din_valid_d = 1'b1;
                        fill_err    = !ctrl_io.s_last;
                    end else if (ctrl_io.s_last) begin
                        wr_ptr_d = '0;
                        fill_err = 1'b1;
                    end else begin
                        wr_ptr_d = wr_ptr_q + AW'(1);
                    end
                end
            end
            BURST: begin
                // rd_ptr wraps to 0 while the final entry is on the core bus
                if (rd_ptr_q == '0) begin
                    state_d    = FILL;
                    burst_done = 1'b1;
                end else begin
                    din_valid_d = 1'b1;
                    rd_ptr_d    = rd_ptr_q + AW'(1);
                end
            end
            default: state_d = FILL;
        endcase
        s_ready_d = (state_d == FILL);
    end

    always_comb begin
        fwd        = ctrl_io.fft_dout_valid && (inflight_q != 2'd0);
        orphan     = ctrl_io.fft_dout_valid && (inflight_q == 2'd0);
        m_valid_d  = fwd;
        m_real_d   = fwd ? ctrl_io.fft_dout_real : '0;
        m_imag_d   = fwd ? ctrl_io.fft_dout_imag : '0;
        m_first_d  = fwd && (bin_q == '0);
        m_last_d   = fwd && (bin_q == LAST_IDX);
        bin_d      = fwd ? bin_q + AW'(1) : bin_q;
        frame_done = m_valid_q && m_last_q;
        frame_d    = frame_done ? frame_q + 8'd1 : frame_q;
        inflight_d = inflight_q;
        overflow   = 1'b0;
        case ({burst_done, frame_done})
            2'b10: begin
                if (inflight_q == 2'd3) begin
                    overflow = 1'b1;
                end else begin
                    inflight_d = inflight_q + 2'd1;
                end
            end
            2'b01: begin
                if (inflight_q != 2'd0) begin
                    inflight_d = inflight_q - 2'd1;
                end
            end
            default: ;
        endcase
        err_set = fill_err || orphan || overflow;
        // A new error outranks a simultaneous clear
        err_d = err_set ? 1'b1 : (ctrl_io.err_clr ? 1'b0 : err_q);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= FILL;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            s_ready_q   <= 1'b0;
            din_valid_q <= 1'b0;
            inflight_q  <= 2'd0;
            bin_q       <= '0;
            frame_q     <= 8'd0;
            m_valid_q   <= 1'b0;
            m_real_q    <= '0;
            m_imag_q    <= '0;
            m_first_q   <= 1'b0;
            m_last_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            s_ready_q   <= s_ready_d;
            din_valid_q <= din_valid_d;
            inflight_q  <= inflight_d;
            bin_q       <= bin_d;
            frame_q     <= frame_d;
            m_valid_q   <= m_valid_d;
            m_real_q    <= m_real_d;
            m_imag_q    <= m_imag_d;
            m_first_q   <= m_first_d;
            m_last_q    <= m_last_d;
            err_q       <= err_d;
        end
    end

    assign ctrl_io.s_ready       = s_ready_q;
    assign ctrl_io.fft_din_valid = din_valid_q;
    assign ctrl_io.fft_din_real  = din_valid_q ? rd_real_q : '0;
    assign ctrl_io.fft_din_imag  = din_valid_q ? rd_imag_q : '0;
    assign ctrl_io.m_valid       = m_valid_q;
    assign ctrl_io.m_real        = m_real_q;
    assign ctrl_io.m_imag        = m_imag_q;
    assign ctrl_io.m_first       = m_first_q;
    assign ctrl_io.m_last        = m_last_q;
    assign ctrl_io.m_frame       = frame_q;
    assign ctrl_io.busy          = (state_q == BURST) || (wr_ptr_q != '0) || (inflight_q != 2'd0);
    assign ctrl_io.err_framing   = err_q;
endmodule

// File: tb/tb_fft64_frame_ctrl.sv
// Scoreboard bench for fft64_frame_ctrl with a behavioural FFT core that
// returns each burst, transformed, a few cycles after it completes.
module tb_fft64_frame_ctrl;
    localparam int DW  = 24;
    localparam int N   = 64;
    localparam int LAT = 5;

    typedef struct packed {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
    } samp_t;

    typedef struct packed {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        logic          first;
        logic          last;
        logic [7:0]    frame;
    } mres_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   cyc  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fft64_frame_ctrl_if #(.DW(DW)) bus ();

    fft64_frame_ctrl #(.DW(DW), .N(N)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .ctrl_io (bus)
    );

    samp_t exp_din [$];
    mres_t exp_m [$];
    samp_t core_q [$];
    int    start_q [$];

    int checks          = 0;
    int failures        = 0;
    int run_len         = 0;
    int exp_run         = N;
    int burst_start_cyc = -1;
    int burst_cnt       = 0;
    int mlast_cnt       = 0;
    int core_in_cnt     = 0;
    int emit_left       = 0;
    int bin_exp         = 0;
    int frame_exp       = 0;
    int din_beat        = 0;
    bit spur_req        = 1'b0;

    // Negedge scoreboard plus behavioural core: compares both DUT streams, then drives the core return path
    task automatic monitor();
        samp_t e, cs;
        mres_t r;
        forever begin
            @(negedge clk);
            if (bus.fft_din_valid) begin
                if (run_len == 0) begin
                    burst_start_cyc = cyc;
                    burst_cnt++;
                end
                run_len++;
                checks++;
                if (exp_din.size() == 0) begin
                    failures++;
                    $display("FAIL din_unexpected got=%h/%h required=none", bus.fft_din_real, bus.fft_din_imag);
                end else begin
                    e = exp_din.pop_front();
                    if ({bus.fft_din_real, bus.fft_din_imag} !== {e.re, e.im}) begin
                        failures++;
                        $display("FAIL din_data beat=%0d got=%h/%h required=%h/%h",
                                 din_beat, bus.fft_din_real, bus.fft_din_imag, e.re, e.im);
                    end
                end
                din_beat++;
                checks++;
                if (bus.s_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL s_ready_in_burst got=%b required=0", bus.s_ready);
                end
                cs.re = bus.fft_din_imag ^ DW'(24'h5A5A5A);
                cs.im = bus.fft_din_real + DW'(7);
                core_q.push_back(cs);
                core_in_cnt++;
                if (core_in_cnt == N) begin
                    core_in_cnt = 0;
                    start_q.push_back(cyc + LAT);
                end
            end else begin
                if (run_len != 0) begin
                    checks++;
                    if (run_len != exp_run) begin
                        failures++;
                        $display("FAIL burst_len got=%0d required=%0d", run_len, exp_run);
                    end
                    if (exp_run == N) begin
                        checks++;
                        if (bus.s_ready !== 1'b1) begin
                            failures++;
                            $display("FAIL s_ready_after_burst got=%b required=1", bus.s_ready);
                        end
                    end
                    run_len  = 0;
                    din_beat = 0;
                end
                checks++;
                if ({bus.fft_din_real, bus.fft_din_imag} !== '0) begin
                    failures++;
                    $display("FAIL din_idle_data got=%h/%h required=0/0", bus.fft_din_real, bus.fft_din_imag);
                end
            end

            if (bus.m_valid) begin
                checks++;
                if (exp_m.size() == 0) begin
                    failures++;
                    $display("FAIL m_unexpected got=%h/%h required=no m_valid", bus.m_real, bus.m_imag);
                end else begin
                    r = exp_m.pop_front();
                    if ({bus.m_real, bus.m_imag, bus.m_first, bus.m_last, bus.m_frame} !== r) begin
                        failures++;
                        $display("FAIL m_beat got=%h/%h f=%b l=%b fr=%0d required=%h/%h f=%b l=%b fr=%0d",
                                 bus.m_real, bus.m_imag, bus.m_first, bus.m_last, bus.m_frame,
                                 r.re, r.im, r.first, r.last, r.frame);
                    end
                end
                if (bus.m_last) mlast_cnt++;
            end else begin
                checks++;
                if ({bus.m_real, bus.m_imag, bus.m_first, bus.m_last} !== '0) begin
                    failures++;
                    $display("FAIL m_idle got=%h/%h f=%b l=%b required=0", bus.m_real, bus.m_imag, bus.m_first, bus.m_last);
                end
            end

            bus.fft_dout_valid = 1'b0;
            bus.fft_dout_real  = '0;
            bus.fft_dout_imag  = '0;
            if (emit_left == 0 && start_q.size() > 0 && cyc >= start_q[0]) begin
                void'(start_q.pop_front());
                emit_left = N;
            end
            if (emit_left > 0 && core_q.size() > 0) begin
                cs = core_q.pop_front();
                emit_left--;
                bus.fft_dout_valid = 1'b1;
                bus.fft_dout_real  = cs.re;
                bus.fft_dout_imag  = cs.im;
                r.re    = cs.re;
                r.im    = cs.im;
                r.first = (bin_exp == 0);
                r.last  = (bin_exp == N - 1);
                r.frame = 8'(frame_exp);
                exp_m.push_back(r);
                if (bin_exp == N - 1) begin
                    bin_exp   = 0;
                    frame_exp = (frame_exp + 1) % 256;
                end else begin
                    bin_exp++;
                end
            end else if (spur_req) begin
                spur_req = 1'b0;
                bus.fft_dout_valid = 1'b1;
                bus.fft_dout_real  = DW'(24'h000123);
                bus.fft_dout_imag  = DW'(24'h000456);
            end
        end
    endtask

    task automatic send_beat(input logic [DW-1:0] re, input logic [DW-1:0] im, input bit last, output bit ok);
        int w;
        w  = 0;
        ok = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_real  = re;
        bus.s_imag  = im;
        bus.s_last  = last;
        while (!ok && w < 300) begin
            @(negedge clk);
            ok = bus.s_ready;
            @(posedge clk);
            #1;
            w++;
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        bus.s_real  = '0;
        bus.s_imag  = '0;
    endtask

    // kind 0 = delta, 1 = random; last_beat<0 means s_last never asserted
    task automatic send_frame(input int kind, input int last_beat, input bit gaps);
        int            nbeats;
        int            c_acc;
        bit            full, ok;
        logic [DW-1:0] re, im;
        samp_t         s;
        full   = (last_beat == N - 1) || (last_beat < 0);
        nbeats = full ? N : last_beat + 1;
        for (int b = 0; b < nbeats; b++) begin
            if (kind == 0) begin
                re = (b == 0) ? DW'(1) : '0;
                im = '0;
            end else begin
                re = DW'($urandom);
                im = DW'($urandom);
            end
            if (full) begin
                s.re = re;
                s.im = im;
                exp_din.push_back(s);
            end
            send_beat(re, im, (b == last_beat), ok);
            if (!ok) begin
                checks++;
                failures++;
                $display("FAIL accept_timeout beat=%0d got=s_ready 0 required=s_ready 1", b);
                return;
            end
            if (gaps && b != nbeats - 1) begin
                @(posedge clk);
                #1;
            end
        end
        if (full) begin
            c_acc = cyc;
            checks++;
            if (bus.s_ready !== 1'b0 || bus.busy !== 1'b1) begin
                failures++;
                $display("FAIL fill_done_state got=ready %b busy %b required=ready 0 busy 1", bus.s_ready, bus.busy);
            end
            @(posedge clk);
            #1;
            checks++;
            if (burst_start_cyc != c_acc) begin
                failures++;
                $display("FAIL burst_start got=%0d required=%0d", burst_start_cyc, c_acc);
            end
        end
    endtask

    task automatic wait_mlast(input int target, input int bound, output bit ok);
        int n;
        n = 0;
        while (mlast_cnt < target && n < bound) begin
            @(posedge clk);
            #1;
            n++;
        end
        ok = (mlast_cnt >= target);
    endtask

    task automatic pulse_clr();
        bus.err_clr = 1'b1;
        @(posedge clk);
        #1;
        bus.err_clr = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.s_ready, bus.fft_din_valid, bus.fft_din_real, bus.fft_din_imag, bus.m_valid, bus.m_real,
             bus.m_imag, bus.m_first, bus.m_last, bus.m_frame, bus.busy, bus.err_framing} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=rdy %b dv %b mv %b fr %0d busy %b err %b required=all 0",
                     bus.s_ready, bus.fft_din_valid, bus.m_valid, bus.m_frame, bus.busy, bus.err_framing);
        end
        rstn = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.s_ready !== 1'b1 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL ready_after_reset got=rdy %b busy %b required=rdy 1 busy 0", bus.s_ready, bus.busy);
        end
    endtask

    task automatic test_delta();
        bit ok;
        send_frame(0, N - 1, 1'b0);
        wait_mlast(mlast_cnt + 1, 400, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL delta_timeout got=no m_last required=m_last");
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.err_framing !== 1'b0) begin
            failures++;
            $display("FAIL delta_after got=busy %b err %b required=busy 0 err 0", bus.busy, bus.err_framing);
        end
        $display("delta frame done: checks=%0d", checks);
    endtask

    task automatic test_gaps();
        bit ok;
        send_frame(1, N - 1, 1'b1);
        wait_mlast(mlast_cnt + 1, 400, ok);
        checks++;
        if (!ok || exp_m.size() != 0 || exp_din.size() != 0) begin
            failures++;
            $display("FAIL gaps_drain got=ok %b m %0d din %0d required=ok 1 m 0 din 0", ok, exp_m.size(), exp_din.size());
        end
        $display("gapped frame done: checks=%0d", checks);
    endtask

    task automatic test_framing();
        bit ok;
        int bursts;
        bursts = burst_cnt;
        send_frame(1, 10, 1'b0);
        checks++;
        if (bus.err_framing !== 1'b1 || bus.busy !== 1'b0 || bus.s_ready !== 1'b1) begin
            failures++;
            $display("FAIL short_frame got=err %b busy %b rdy %b required=err 1 busy 0 rdy 1",
                     bus.err_framing, bus.busy, bus.s_ready);
        end
        repeat (80) @(posedge clk);
        #1;
        checks++;
        if (burst_cnt != bursts) begin
            failures++;
            $display("FAIL short_no_burst got=%0d required=%0d", burst_cnt, bursts);
        end
        send_frame(1, N - 1, 1'b0);
        wait_mlast(mlast_cnt + 1, 400, ok);
        checks++;
        if (!ok || bus.err_framing !== 1'b1) begin
            failures++;
            $display("FAIL after_short got=ok %b err %b required=ok 1 err 1", ok, bus.err_framing);
        end
        pulse_clr();
        checks++;
        if (bus.err_framing !== 1'b0) begin
            failures++;
            $display("FAIL err_clr got=%b required=0", bus.err_framing);
        end
        send_frame(1, -1, 1'b0);
        checks++;
        if (bus.err_framing !== 1'b1) begin
            failures++;
            $display("FAIL missing_last got=%b required=1", bus.err_framing);
        end
        wait_mlast(mlast_cnt + 1, 400, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL missing_last_burst got=no m_last required=m_last");
        end
        pulse_clr();
        $display("framing errors done: checks=%0d", checks);
    endtask

    task automatic test_spurious();
        spur_req = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.m_valid !== 1'b0) begin
                failures++;
                $display("FAIL spurious_mvalid got=%b required=0", bus.m_valid);
            end
        end
        checks++;
        if (bus.err_framing !== 1'b1 || spur_req !== 1'b0) begin
            failures++;
            $display("FAIL spurious_err got=%b required=1", bus.err_framing);
        end
        pulse_clr();
        $display("spurious core output done: checks=%0d", checks);
    endtask

    task automatic test_reset_mid_burst();
        bit ok;
        int n;
        send_frame(1, N - 1, 1'b0);
        n = 0;
        while (run_len != 19 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (run_len != 19) begin
            failures++;
            $display("FAIL burst_progress got=%0d required=19", run_len);
        end
        exp_run = 20;
        rstn = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({bus.s_ready, bus.fft_din_valid, bus.fft_din_real, bus.fft_din_imag, bus.m_valid,
             bus.m_frame, bus.busy, bus.err_framing} !== '0) begin
            failures++;
            $display("FAIL reset_mid_burst got=rdy %b dv %b mv %b busy %b err %b required=all 0",
                     bus.s_ready, bus.fft_din_valid, bus.m_valid, bus.busy, bus.err_framing);
        end
        exp_din.delete();
        core_q.delete();
        core_in_cnt = 0;
        bin_exp     = 0;
        frame_exp   = 0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        exp_run = N;
        send_frame(1, N - 1, 1'b0);
        wait_mlast(mlast_cnt + 1, 400, ok);
        checks++;
        if (!ok || bus.err_framing !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_frame got=ok %b err %b busy %b required=ok 1 err 0 busy 0",
                     ok, bus.err_framing, bus.busy);
        end
        $display("reset mid burst done: checks=%0d", checks);
    endtask

    task automatic test_back_to_back();
        bit ok;
        int target;
        rstn = 1'b0;
        @(posedge clk);
        #1;
        bin_exp   = 0;
        frame_exp = 0;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        target = mlast_cnt + 2;
        send_frame(1, N - 1, 1'b0);
        send_frame(1, N - 1, 1'b0);
        wait_mlast(target, 600, ok);
        checks++;
        if (!ok || bus.err_framing !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL back_to_back got=ok %b err %b busy %b required=ok 1 err 0 busy 0",
                     ok, bus.err_framing, bus.busy);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (exp_m.size() != 0 || exp_din.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=m %0d din %0d required=0 0", exp_m.size(), exp_din.size());
        end
        $display("back to back frames done: checks=%0d", checks);
    endtask

    initial begin
        bus.s_valid        = 1'b0;
        bus.s_real         = '0;
        bus.s_imag         = '0;
        bus.s_last         = 1'b0;
        bus.fft_dout_valid = 1'b0;
        bus.fft_dout_real  = '0;
        bus.fft_dout_imag  = '0;
        bus.err_clr        = 1'b0;
        fork
            monitor();
        join_none
        test_reset();
        test_delta();
        test_gaps();
        test_framing();
        test_spurious();
        test_reset_mid_burst();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fft64_frame_ctrl.md
FFT64_FRAME_CTRL -- requirements
Module: fft64_frame_ctrl

Interface
REQ-001 SHALL have parameter DW, default 24: width of the real and imaginary sample fields.
REQ-002 SHALL have parameter N, default 64: samples per FFT frame, a power of two.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rstn, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port s_valid, input, 1 bit: an upstream sample is present.
REQ-006 SHALL have port s_ready, output, 1 bit: the block accepts a sample this cycle.
REQ-007 SHALL have ports s_real and s_imag, input, DW bits each: upstream sample, signed.
REQ-008 SHALL have port s_last, input, 1 bit: upstream marks the final sample of a frame.
REQ-009 SHALL have port fft_din_valid, output, 1 bit: drives the fft64_core din_valid input.
REQ-010 SHALL have ports fft_din_real and fft_din_imag, output, DW bits each: drive the core inputs.
REQ-011 SHALL have port fft_dout_valid, input, 1 bit: the core dout_valid output.
REQ-012 SHALL have ports fft_dout_real and fft_dout_imag, input, DW bits each: core outputs.
REQ-013 SHALL have port m_valid, output, 1 bit: a result sample is present; there is no backpressure.
REQ-014 SHALL have ports m_real and m_imag, output, DW bits each: result sample.
REQ-015 SHALL have ports m_first and m_last, output, 1 bit each: bin 0 and bin N-1 of a frame.
REQ-016 SHALL have port m_frame, output, 8 bits: frame index of the current result sample.
REQ-017 SHALL have port busy, output, 1 bit: a frame is partially loaded, bursting, or in flight.
REQ-018 SHALL have port err_framing, output, 1 bit: sticky error flag.
REQ-019 SHALL have port err_clr, input, 1 bit: clears err_framing.

Function
REQ-020 SHALL implement a two-state FSM, FILL and BURST, backed by an N-entry sample buffer, a write pointer wr_ptr and a read pointer rd_ptr.
REQ-021 FILL: s_ready=1; each s_valid&&s_ready beat writes the buffer at wr_ptr and increments wr_ptr; upstream gaps are tolerated.
REQ-022 FILL, accepted beat with wr_ptr=N-1: the FSM moves to BURST and wr_ptr wraps to 0.
REQ-023 s_last accepted with wr_ptr<N-1: err_framing is set, the partial frame is discarded, wr_ptr goes to 0 and the FSM stays in FILL.
REQ-024 s_last=0 on the beat with wr_ptr=N-1: err_framing is set and the frame is still bursted.
REQ-025 BURST: s_ready=0; fft_din_valid is registered high for exactly N consecutive cycles, starting the cycle after the N-th accept, carrying buffer entries rd_ptr=0..N-1 in order.
REQ-026 BURST: after the N-th burst cycle the FSM returns to FILL, so s_ready=1 on the next cycle.
REQ-027 fft_din_real and fft_din_imag SHALL be 0 whenever fft_din_valid=0.
REQ-028 An inflight counter (0..3) SHALL increment at burst end and decrement on each m_last.
REQ-029 Simultaneous increment and decrement of inflight SHALL leave it unchanged; an increment at 3 SHALL saturate and set err_framing.
REQ-030 m_valid, m_real and m_imag SHALL register fft_dout_* with 1-cycle latency; outputs are 0 when m_valid=0.
REQ-031 An output bin counter SHALL advance on each forwarded sample and wrap N-1->0.
REQ-032 m_first SHALL assert at bin 0 and m_last at bin N-1; m_frame SHALL increment after m_last, wrapping 255->0.
REQ-033 fft_dout_valid while inflight=0 SHALL set err_framing; that sample is dropped (m_valid=0, bin counter unchanged).
REQ-034 busy SHALL equal (state==BURST)||(wr_ptr!=0)||(inflight!=0).
REQ-035 err_clr SHALL clear err_framing; a set condition in the same cycle wins.

Reset
REQ-036 rstn=0 at a clock edge SHALL force FILL, wr_ptr=rd_ptr=0, inflight=0, bin=0, m_frame=0, err_framing=0, and all valid, first, last, data and busy outputs to 0; s_ready is 0 during reset.
REQ-037 Reset mid-BURST SHALL drop fft_din_valid at the next edge; no partial frame resumes after reset; buffer contents need not be cleared.

Verification
REQ-038 Delta frame (sample 0 = 1, rest 0, s_last on beat 63) -> 64 contiguous fft_din_valid cycles; 64 m_valid beats with m_first on bin 0, m_last on bin 63, m_frame=0; busy falls after m_last.
REQ-039 Upstream s_valid toggling 1/0 while filling 64 beats -> the burst remains exactly 64 contiguous cycles with data in order; s_ready=0 throughout BURST.
REQ-040 s_last on beat 10 -> err_framing=1, no burst, wr_ptr=0; the next correct 64-beat frame bursts normally; err_clr pulse -> err_framing=0.
REQ-041 Two back-to-back frames -> second burst starts ≥1 cycle after the second fill completes; output m_frame=0 then 1; inflight never exceeds 2.
REQ-042 fft_dout_valid pulsed with no frame submitted -> err_framing=1, m_valid stays 0.
REQ-043 rstn=0 on burst cycle 20 -> fft_din_valid=0 at the next edge; all outputs at reset values; a fresh frame then bursts correctly.
